gen_sequencer: RTL
==================

// Module: gen_sequencer
// PURPOSE
//  Parametrised phase sequencer for the Life cell array. It steps a position index
//  across POS_COUNT array slices and runs LOAD -> EVAL -> STORE phases per slice.
//  Adds start/stop/single-step control, a memory write handshake and a generation counter.
//  Sits between the top-level controls and the cell array / generation memory.
// PARAMETERS
//  POS_COUNT  4   number of array slices per generation (>=1)
//  POS_W      2   width of pos; $clog2(POS_COUNT), minimum 1
//  GEN_W      16  width of generation counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-high
//  start        in   1      level/pulse: enter continuous run from IDLE
//  stop         in   1      pulse: halt at next generation boundary
//  step         in   1      pulse: run exactly one generation from IDLE
//  mem_ready    in   1      memory accepts write_mem this cycle
//  pos          out  POS_W  current slice index
//  write_array  out  1      load slice into array (LOAD phase)
//  run          out  1      array evaluates slice (EVAL phase)
//  write_mem    out  1      write request to memory (STORE phase)
//  busy         out  1      state != IDLE
//  gen_done     out  1      1-cycle pulse: generation completed
//  generation   out  GEN_W  completed-generation count
// BEHAVIOUR
//  - Reset: on rst sampled high, state=IDLE, pos=0, generation=0, continuous=0.
//    All other outputs are 0. Reset overrides every other input, including mid-STORE.
//  - Outputs are Moore decodes of registered state:
//    write_array=LOAD, run=EVAL, write_mem=STORE, busy=!IDLE.
//  - IDLE: start -> LOAD with continuous=1. step -> LOAD with continuous=0.
//    start and step together: start wins. stop in IDLE: no effect.
//  - LOAD -> EVAL -> STORE: one cycle each, no waiting.
//  - STORE: hold write_mem=1 until mem_ready=1. mem_ready outside STORE is ignored.
//    On the handshake, if pos<POS_COUNT-1: pos++ and go to LOAD.
//    If pos==POS_COUNT-1: pos=0, generation++, gen_done=1 next cycle,
//    then go to LOAD if continuous else IDLE.
//  - stop: sampled in any non-IDLE state. It clears continuous; the current generation completes.
//    stop on the same cycle as the last handshake: that generation ends, then IDLE.
//  - start/step while busy: ignored.
//  - Wrap: generation wraps from 2^GEN_W-1 to 0 and gen_done still pulses.
//  - POS_COUNT==1: pos is constant 0. A generation is LOAD, EVAL, STORE.
//  - Latency: start at edge t gives write_array=1, pos=0 after edge t.
//    Minimum generation = 3*POS_COUNT cycles.
// STRUCTURE
//  - gol_ctrl_pkg: state enum (IDLE, LOAD, EVAL, STORE) and the 2-bit state width.
//    The same package is shared with the array and memory blocks.
//  - One sub-module, gol_wrap_counter (params MAX, W; inc, clr, wrap out).
//    It is instantiated for pos (MAX=POS_COUNT-1) and for generation (MAX=2^GEN_W-1).
// TESTING
//  1. rst 3 cycles, then idle 5 cycles -> all outputs 0, pos=0, generation=0.
//  2. mem_ready tied 1, step pulse -> 12-cycle sequence (POS_COUNT=4):
//     pos 0..3, phases W/R/M per slice, gen_done once, generation=1, then IDLE.
//  3. start, mem_ready stalls 3 cycles at pos=2 -> write_mem held 4 cycles, pos frozen.
//     Sequence then resumes and generations keep counting.
//  4. start, stop during pos=1 of gen 0 -> gen 0 completes, generation=1, busy falls.
//     No LOAD follows.
//  5. GEN_W=2, continuous run of 5 gens -> generation 1,2,3,0,1, with 5 gen_done pulses.
//  6. rst asserted mid-STORE with mem_ready=1 -> next cycle IDLE, generation=0, write_mem=0.

Source files
------------

// File: rtl/gol_ctrl_pkg.sv
// Shared control definitions for the Life sequencer, cell array and generation memory.
package gol_ctrl_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StEval  = 2'd2,
    StStore = 2'd3
  } state_e;

endpackage

// File: rtl/gol_wrap_counter.sv
// Modulo-(MAX+1) counter; o_wrap flags the increment that rolls MAX back to zero.
module gol_wrap_counter #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(MAX));
  assign o_wrap   = i_inc && w_at_max;
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_at_max ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/gen_sequencer.sv
// Steps slices through LOAD -> EVAL -> STORE, with run/stop/step control and a
// generation counter.
module gen_sequencer
  import gol_ctrl_pkg::*;
#(
  parameter int unsigned POS_COUNT = 4,
  parameter int unsigned POS_W     = 2,
  parameter int unsigned GEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             mem_ready,
  output logic [POS_W-1:0] pos,
  output logic             write_array,
  output logic             run,
  output logic             write_mem,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] generation
);

  state_e r_state;
  logic   r_continuous;
  logic   r_gen_done;
  logic   w_handshake;
  logic   w_pos_wrap;

  assign w_handshake = (r_state == StStore) && mem_ready;

  gol_wrap_counter #(
    .MAX (POS_COUNT - 1),
    .W   (POS_W)
  ) u_pos_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_handshake),
    .i_clr   (1'b0),
    .o_count (pos),
    .o_wrap  (w_pos_wrap)
  );

  gol_wrap_counter #(
    .MAX ((2 ** GEN_W) - 1),
    .W   (GEN_W)
  ) u_gen_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_pos_wrap),
    .i_clr   (1'b0),
    .o_count (generation),
    .o_wrap  ()
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_continuous <= 1'b0;
      r_gen_done   <= 1'b0;
    end else begin
      r_gen_done <= w_pos_wrap;
      if (r_state != StIdle && stop) begin
        r_continuous <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state      <= StLoad;
            r_continuous <= 1'b1;
          end else if (step) begin
            r_state      <= StLoad;
            r_continuous <= 1'b0;
          end
        end
        StLoad: r_state <= StEval;
        StEval: r_state <= StStore;
        StStore: begin
          if (mem_ready) begin
            // A stop on the final handshake must still end the run here.
            if (w_pos_wrap) begin
              r_state <= (r_continuous && !stop) ? StLoad : StIdle;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign write_array = (r_state == StLoad);
  assign run         = (r_state == StEval);
  assign write_mem   = (r_state == StStore);
  assign busy        = (r_state != StIdle);
  assign gen_done    = r_gen_done;

endmodule
